// File: rtl/pic_pkg.sv
// Shared types and constants for the host-side PIC interrupt-acknowledge logic.
package pic_pkg;

    localparam int VEC_W = 8;
    localparam int CNT_W = 4;

    localparam logic INTA_ASSERT   = 1'b0;
    localparam logic INTA_DEASSERT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1_LOW,
        ST_GAP,
        ST_P2_LOW,
        ST_HOLD,
        ST_RECOVER
    } inta_state_t;

    function automatic logic inta_low(input inta_state_t s);
        return (s == ST_P1_LOW) || (s == ST_P2_LOW);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous PIC outputs; 2-cycle latency, no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pic_inta_sequencer.sv
// Generates the two INTA pulses for an 8259-style PIC and hands the captured vector to the CPU.
// INTA falls 3 edges after INT; vec_valid holds (vector stable) until vec_ready.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             INT,
    input  logic             enable,
    input  logic [VEC_W-1:0] data_Bus,
    output logic             INTA,
    output logic             vec_valid,
    output logic [VEC_W-1:0] vec_data,
    input  logic             vec_ready,
    output logic             busy
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    inta_state_t      state;
    inta_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             capture;
    logic             int_s;

    sync_2ff u_int_sync (
        .clk   (clk),
        .reset (reset),
        .d     (INT),
        .q     (int_s)
    );

    // Once started, a sequence always runs to completion: aborting would
    // leave the PIC waiting for its second pulse.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (int_s && enable) begin
                    state_next = ST_P1_LOW;
                    cnt_next   = PULSE_LOAD;
                end
            end
            ST_P1_LOW: begin
                if (cnt == '0) begin
                    state_next = ST_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_next = ST_P2_LOW;
                    cnt_next   = PULSE_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_P2_LOW: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (vec_ready) begin
                    state_next = ST_RECOVER;
                    cnt_next   = GAP_LOAD;
                end
            end
            ST_RECOVER: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // INTA and vec_valid are decoded from the next state so both are true flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            INTA      <= INTA_DEASSERT;
            vec_valid <= 1'b0;
            vec_data  <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            INTA      <= inta_low(state_next) ? INTA_ASSERT : INTA_DEASSERT;
            vec_valid <= (state_next == ST_HOLD);
            if (capture) begin
                vec_data <= data_Bus;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_pic_inta_sequencer.sv
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_in;
    logic       int_fast;
    logic       enable;
    logic       vec_ready;
    logic [7:0] data_bus;

    logic       inta, vec_valid, busy;
    logic [7:0] vec_data;
    logic       inta_f, vld_f, busy_f;
    logic [7:0] data_f;

    int passed = 0;
    int total  = 0;
    int xfers  = 0;

    always #5 clk = ~clk;

    pic_inta_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .INT       (int_in),
        .enable    (enable),
        .data_Bus  (data_bus),
        .INTA      (inta),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (vec_ready),
        .busy      (busy)
    );

    pic_inta_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(1)) dut_fast (
        .clk       (clk),
        .reset     (reset),
        .INT       (int_fast),
        .enable    (enable),
        .data_Bus  (data_bus),
        .INTA      (inta_f),
        .vec_valid (vld_f),
        .vec_data  (data_f),
        .vec_ready (vec_ready),
        .busy      (busy_f)
    );

    always @(posedge clk) begin
        if (!reset && vec_valid && vec_ready) xfers <= xfers + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    typedef struct {
        logic       int_in;
        logic       en;
        logic       rdy;
        logic [7:0] dat;
        logic       inta;
        logic       vld;
        logic [7:0] vdat;
        logic       busy;
    } vec_t;

    vec_t tbl[13];

    logic [0:12] e_inta = 13'b1100110011111;
    logic [0:12] e_vld  = 13'b0000000010000;
    logic [0:12] e_busy = 13'b0011111111100;
    logic [0:7]  f_inta = 8'b11010111;
    logic [0:7]  f_vld  = 8'b00000100;
    logic [0:7]  f_busy = 8'b00111110;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (inta !== 1'b0 && n < 20) begin
            tick;
            n++;
        end
    endtask

    initial begin
        int n;
        int x0;
        logic seen_low;

        for (int i = 0; i < 13; i++) begin
            tbl[i].int_in = (i < 4);
            tbl[i].en     = 1'b1;
            tbl[i].rdy    = 1'b1;
            tbl[i].dat    = (i == 8) ? 8'h4A : 8'hFF;
            tbl[i].inta   = e_inta[i];
            tbl[i].vld    = e_vld[i];
            tbl[i].vdat   = (i >= 8) ? 8'h4A : 8'h00;
            tbl[i].busy   = e_busy[i];
        end

        reset = 1'b1; int_in = 1'b0; int_fast = 1'b0; enable = 1'b0;
        vec_ready = 1'b0; data_bus = 8'h00;
        tick; tick;
        check("reset_main", 32'({inta, vec_valid, vec_data, busy}), 32'({1'b1, 1'b0, 8'h00, 1'b0}));
        check("reset_fast", 32'({inta_f, vld_f, data_f, busy_f}), 32'({1'b1, 1'b0, 8'h00, 1'b0}));
        reset = 1'b0;

        // Basic acknowledge, one row per clock edge
        for (int i = 0; i < 13; i++) begin
            int_in    = tbl[i].int_in;
            enable    = tbl[i].en;
            vec_ready = tbl[i].rdy;
            data_bus  = tbl[i].dat;
            tick;
            check($sformatf("basic[%0d]", i), 32'({inta, vec_valid, vec_data, busy}),
                  32'({tbl[i].inta, tbl[i].vld, tbl[i].vdat, tbl[i].busy}));
        end
        check("basic_xfers", 32'(xfers), 32'(1));

        // Backpressure
        int_in = 1'b1; data_bus = 8'h4C; vec_ready = 1'b0; n = 0;
        while (vec_valid !== 1'b1 && n < 30) begin
            tick;
            n++;
            if (n == 3) int_in = 1'b0;
        end
        check("bp_latency", 32'(n), 32'(9));
        x0 = xfers;
        for (int k = 0; k < 5; k++) begin
            tick;
            check($sformatf("bp_hold[%0d]", k), 32'({inta, vec_valid, vec_data}),
                  32'({1'b1, 1'b1, 8'h4C}));
        end
        vec_ready = 1'b1;
        tick;
        check("bp_release", 32'(vec_valid), 32'(0));
        tick; tick;
        check("bp_idle", 32'(busy), 32'(0));
        check("bp_xfers", 32'(xfers - x0), 32'(1));

        // INT withdrawn after pulse 1: spurious IR7 vector passes through
        int_in = 1'b1; data_bus = 8'h47;
        wait_fall(n);
        check("wd_latency", 32'(n), 32'(3));
        int_in = 1'b0;
        tick; tick;
        check("wd_gap", 32'(inta), 32'(1));
        tick; tick;
        check("wd_p2", 32'(inta), 32'(0));
        tick; tick;
        check("wd_vec", 32'({vec_valid, vec_data}), 32'({1'b1, 8'h47}));
        tick; tick; tick;
        check("wd_idle", 32'({vec_valid, busy}), 32'(0));

        // Reset during pulse 2
        int_in = 1'b1; data_bus = 8'h55;
        wait_fall(n);
        int_in = 1'b0;
        tick; tick; tick; tick;
        check("rst_in_p2", 32'(inta), 32'(0));
        x0 = xfers;
        reset = 1'b1;
        tick;
        check("rst_outputs", 32'({inta, vec_valid, vec_data, busy}), 32'({1'b1, 1'b0, 8'h00, 1'b0}));
        reset = 1'b0;
        repeat (12) tick;
        check("rst_no_vec", 32'(xfers - x0), 32'(0));
        check("rst_quiet", 32'({inta, vec_valid, busy}), 32'({1'b1, 1'b0, 1'b0}));

        // Enable gating, then back-to-back service with INT held high
        enable = 1'b0; int_in = 1'b1; data_bus = 8'h4A; seen_low = 1'b0;
        repeat (6) begin
            tick;
            if (inta === 1'b0) seen_low = 1'b1;
        end
        check("gate_no_pulse", 32'({seen_low, busy}), 32'(0));
        enable = 1'b1;
        tick;
        check("gate_fall", 32'(inta), 32'(0));
        for (int k = 1; k <= 16; k++) begin
            tick;
            if (k == 6) begin
                check("b2b_vec1", 32'({vec_valid, vec_data}), 32'({1'b1, 8'h4A}));
                data_bus = 8'h4B;
            end
            if (k == 9) check("b2b_idle", 32'({inta, busy}), 32'({1'b1, 1'b0}));
            if (k == 10) begin
                check("b2b_fall", 32'(inta), 32'(0));
                int_in = 1'b0;
            end
            if (k == 16) check("b2b_vec2", 32'({vec_valid, vec_data}), 32'({1'b1, 8'h4B}));
        end
        repeat (4) tick;
        check("b2b_done", 32'(busy), 32'(0));

        // PULSE_CYCLES=1, GAP_CYCLES=1 instance
        int_fast = 1'b1; data_bus = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) int_fast = 1'b0;
            data_bus = (i == 5) ? 8'h5A : 8'hFF;
            tick;
            check($sformatf("fast[%0d]", i), 32'({inta_f, vld_f, busy_f}),
                  32'({f_inta[i], f_vld[i], f_busy[i]}));
        end
        check("fast_vec", 32'(data_f), 32'(8'h5A));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pic_inta_sequencer.md
# pic_inta_sequencer

Host-side interrupt acknowledge engine on the CPU side of the 8259-style PIC. It watches the PIC's `INT` output and generates the two active-low `INTA` pulses the PIC expects. It captures the 8-bit vector the PIC drives onto `data_Bus` during the second pulse and hands it to the CPU core through a valid/ready handshake. It is the direct downstream consumer of `INT` and the sole driver of the PIC's `INTA` input.

## Interface
- `PULSE_CYCLES`, default 2: clocks `INTA` is held low per pulse; legal range 1..15.
- `GAP_CYCLES`, default 2: clocks `INTA` is high between pulse 1 and pulse 2, and also the post-handshake recovery time; legal range 1..15.
- `clk`, input, 1: single system clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `INT`, input, 1: PIC interrupt request; asynchronous to `clk`.
- `enable`, input, 1: allows a new acknowledge sequence to start.
- `data_Bus`, input, 8: PIC data bus; carries the vector while `INTA` is low on pulse 2.
- `INTA`, output, 1: active-low acknowledge to the PIC; registered.
- `vec_valid`, output, 1: captured vector available.
- `vec_data`, output, 8: captured vector.
- `vec_ready`, input, 1: CPU accepts the vector.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- `INT` passes through a 2-flop synchronizer, producing `int_s`. Nothing else samples `INT` directly.
- FSM states: IDLE, P1_LOW, GAP, P2_LOW, HOLD, RECOVER.
- **IDLE:** `INTA`=1, `busy`=0. If `int_s` && `enable`, go to P1_LOW and load `cnt`=PULSE_CYCLES-1.
- **P1_LOW:** `INTA`=0. Decrement `cnt`. When `cnt`==0, go to GAP and load GAP_CYCLES-1.
- **GAP:** `INTA`=1. When `cnt`==0, go to P2_LOW and load PULSE_CYCLES-1.
- **P2_LOW:** `INTA`=0. On the edge where `cnt`==0, capture `data_Bus` into `vec_data` and go to HOLD.
- **HOLD:** `INTA`=1, `vec_valid`=1. If `vec_ready`, go to RECOVER and load GAP_CYCLES-1. `vec_data` stays stable while `vec_valid` is high.
- **RECOVER:** `INTA`=1, `vec_valid`=0. When `cnt`==0, return to IDLE.
- `cnt` is 4 bits and unsigned. It is never decremented below 0.
- A started sequence always completes both pulses, even if `int_s` drops or `enable` falls. Aborting would desynchronize the PIC. If `INT` is withdrawn, the PIC itself supplies the IR7 spurious vector, which is passed through unchanged.
- A re-asserted `INT` during HOLD or RECOVER is ignored until IDLE. It is then serviced on the first IDLE cycle.

## Timing
- Reset values: `INTA`=1, `vec_valid`=0, `vec_data`=8'h00, `busy`=0, state=IDLE, `cnt`=0, synchronizer flops=0.
- `INTA` and `vec_valid` are registered outputs. Reset mid-sequence forces `INTA`=1 on the next edge.
- Request latency: `INT` rising before edge t gives `int_s`=1 after edge t+1. `INTA` falls after edge t+2, assuming `enable`=1.
- Pulse 1 is PULSE_CYCLES low, followed by GAP_CYCLES high. Pulse 2 is PULSE_CYCLES low.
- The vector is sampled on the final low cycle of pulse 2. `vec_valid` rises on the same edge that returns `INTA` high.
- Total from the first `INTA` fall to `vec_valid` is 2·PULSE_CYCLES + GAP_CYCLES cycles.
- Handshake: the transfer occurs on an edge where `vec_valid` && `vec_ready`. `vec_valid` drops on that edge.
- If `vec_ready` is already high when `vec_valid` rises, HOLD lasts exactly 1 cycle.
- Minimum spacing between back-to-back acknowledge sequences: 1 HOLD cycle + GAP_CYCLES + 1 IDLE cycle.

## Structure
- Shared package `pic_pkg`:
  - state enum `inta_state_t`
  - `INTA_ASSERT`=1'b0 and `INTA_DEASSERT`=1'b1
  - `VEC_W`=8 and `CNT_W`=4
- Sub-module `sync_2ff`: single-bit 2-flop synchronizer with synchronous reset. It is reused for `INT` and any other asynchronous PIC outputs.

## Test plan
- **Basic acknowledge.** Defaults; PIC model drives 8'h4A during pulse 2; `vec_ready`=1. Expect:
  - `INTA` low for 2 cycles, high for 2, low for 2
  - `vec_valid` 1 cycle with `vec_data`=8'h4A
  - `busy` low again after 2 RECOVER cycles
- **Backpressure.** Hold `vec_ready`=0 for 5 cycles after `vec_valid` rises. Expect `vec_valid` high and `vec_data` stable for 6 cycles, no `INTA` activity, and a single transfer.
- **INT withdrawn after pulse 1.** PIC drives 8'h47 (IR7 spurious) on pulse 2. Expect pulse 2 still issued and `vec_data`=8'h47.
- **Reset mid-sequence.** Assert `reset` during P2_LOW. Expect the following after the next edge:
  - `INTA`=1, `vec_valid`=0, `vec_data`=8'h00, `busy`=0
  - no vector delivered
- **Enable gating and back-to-back.** Set `enable`=0 while `INT`=1: no `INTA` pulse. Raise `enable`: `INTA` falls 1 cycle later. Keep `INT` high with a second vector 8'h4B: a second sequence starts exactly after RECOVER plus 1 IDLE cycle.
- **Parameter corner.** Set PULSE_CYCLES=1, GAP_CYCLES=1. Expect single-cycle pulses, a 1-cycle gap, and the vector captured on the pulse-2 cycle.
